dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache controller at the memory stage.
- Responds to the memory-stage read/write enables from the pipeline control.
- Raises block_pipe_data_cache while a miss is serviced, so control freezes all pipeline registers.
- Runs a request/acknowledge line transfer to main memory.

---
 rtl/dcache_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the memory stage.
// A miss freezes the pipeline through block_pipe_data_cache. While frozen,
// the dirty victim is written back if needed, the line is refilled over a
// req/ack link, and the held access is then replayed as a hit.
module dcache_ctrl #(
    parameter int LINES      = 4,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MEM_R_EN,
    input  logic                     MEM_W_EN,
    input  logic                     is_byte,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     block_pipe_data_cache,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_WORDS*32-1:0] mem_wdata,
    input  logic [LINE_WORDS*32-1:0] mem_rdata,
    input  logic                     mem_ack
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - 4 - IDX_W;
    localparam int LINE_W = LINE_WORDS * 32;

    typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } line_meta_t;

    state_t            state;
    line_meta_t        meta_q [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [31:0]       rdata_q;

    logic [1:0]        byte_off;
    logic [1:0]        word_off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              access;
    logic              hit;
    logic [LINE_W-1:0] cur_line;
    logic [31:0]       cur_word;
    logic [7:0]        cur_byte;
    logic [31:0]       load_val;
    logic [31:0]       st_word;
    logic [LINE_W-1:0] st_line;

    assign byte_off = addr[1:0];
    assign word_off = addr[3:2];
    assign idx      = addr[3+IDX_W:4];
    assign tag      = addr[ADDR_W-1:4+IDX_W];

    // A simultaneous read and write enable is handled as a write.
    assign access   = MEM_R_EN | MEM_W_EN;
    assign hit      = meta_q[idx].valid && (meta_q[idx].tag == tag);

    // Word/byte extraction for loads and read-modify-write merge for stores.
    always_comb begin
        cur_line = data_q[idx];
        cur_word = cur_line[{word_off, 5'b0} +: 32];
        cur_byte = cur_word[{byte_off, 3'b0} +: 8];
        load_val = is_byte ? {24'b0, cur_byte} : cur_word;
        st_word  = cur_word;
        if (is_byte)
            st_word[{byte_off, 3'b0} +: 8] = wdata[7:0];
        else
            st_word = wdata;
        st_line = cur_line;
        st_line[{word_off, 5'b0} +: 32] = st_word;
    end

    // Hit data is visible in the same cycle; otherwise the last load result holds.
    assign rdata = (state == IDLE && access && !MEM_W_EN && hit) ? load_val : rdata_q;

    // The stall rises combinationally in the miss-detect cycle and holds for the whole transfer.
    assign block_pipe_data_cache = (state != IDLE) || (access && !hit);

    // Controller FSM: line metadata, the memory handshake and the held load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
            for (int i = 0; i < LINES; i++) meta_q[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        if (hit) begin
                            if (MEM_W_EN) meta_q[idx].dirty <= 1'b1;
                            else          rdata_q           <= load_val;
                        end else if (meta_q[idx].valid && meta_q[idx].dirty) begin
                            state     <= WB;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= {meta_q[idx].tag, idx, 4'b0};
                            mem_wdata <= cur_line;
                        end else begin
                            state    <= REFILL;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag, idx, 4'b0};
                        end
                    end
                end
                WB: begin
                    // mem_req stays high: the refill request follows directly.
                    if (mem_ack) begin
                        meta_q[idx].dirty <= 1'b0;
                        state             <= REFILL;
                        mem_we            <= 1'b0;
                        mem_addr          <= {tag, idx, 4'b0};
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        meta_q[idx] <= '{valid: 1'b1, dirty: 1'b0, tag: tag};
                        state       <= IDLE;
                        mem_req     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line data array: store-hit merges and refill fills. Validity lives in meta_q, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (state == IDLE && access && hit && MEM_W_EN)
            data_q[idx] <= st_line;
        else if (state == REFILL && mem_ack)
            data_q[idx] <= mem_rdata;
    end

endmodule
